// File: rtl/stream_mem_pkg.sv
// Shared types for the burst memory: write/read FSM encodings and the strobe width.
package stream_mem_pkg;

  typedef enum logic       {W_FIRST, W_NEXT}          w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_RUN, R_DRAIN}   r_state_t;

  function automatic int strb_w(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/stream_burst_mem_if.sv
// Write stream, read command and read stream signals of stream_burst_mem.
interface stream_burst_mem_if
  import stream_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_W = strb_w(DATA_WIDTH);

  logic [ADDR_WIDTH-1:0] s_axis_wr_addr;
  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic [STRB_W-1:0]     s_axis_tstrb;
  logic                  s_axis_tvalid;
  logic                  s_axis_tlast;
  logic                  s_axis_tready;
  logic                  rd_start;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] rd_len;
  logic                  rd_busy;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic [STRB_W-1:0]     m_axis_tstrb;
  logic                  m_axis_tvalid;
  logic                  m_axis_tlast;
  logic                  m_axis_tready;

  modport master (
    output s_axis_wr_addr, s_axis_tdata, s_axis_tstrb, s_axis_tvalid, s_axis_tlast,
    output rd_start, rd_addr, rd_len, m_axis_tready,
    input  s_axis_tready, rd_busy, m_axis_tdata, m_axis_tstrb, m_axis_tvalid, m_axis_tlast
  );

  modport slave (
    input  s_axis_wr_addr, s_axis_tdata, s_axis_tstrb, s_axis_tvalid, s_axis_tlast,
    input  rd_start, rd_addr, rd_len, m_axis_tready,
    output s_axis_tready, rd_busy, m_axis_tdata, m_axis_tstrb, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/axis_skid_buf.sv
// Two-entry output FIFO; the head entry drives the stream so payload is stable while stalled.
module axis_skid_buf #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count
);
  logic [WIDTH-1:0] ent0, ent1;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) ent0 <= din;
          else               ent1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          ent0  <= ent1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) ent0 <= din;
          else begin
            ent0 <= ent1;
            ent1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid = (count != 2'd0);
  assign dout  = ent0;
endmodule

// File: rtl/stream_burst_mem.sv
// Byte-strobed burst memory: streamed write bursts in, commanded read bursts out,
// simple dual-port storage so writes are never back-pressured.
module stream_burst_mem
  import stream_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic               axis_aclk,
  input  logic               axis_areset,
  stream_burst_mem_if.slave  bus
);
  localparam int STRB_W = strb_w(DATA_WIDTH);
  localparam int DEPTH  = 2 ** ADDR_WIDTH;

  w_state_t              w_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr;
  logic                  wr_beat;

  r_state_t              r_state, r_state_nxt;
  logic [ADDR_WIDTH-1:0] rd_ptr, rd_ptr_nxt, rd_remain, rd_remain_nxt;
  logic                  rd_issue, rd_vld, rd_last_q, rd_pop, room;
  logic [2:0]            occ;
  logic [STRB_W-1:0][7:0] rd_data;
  logic [STRB_W-1:0][7:0] mem [DEPTH];

  logic                  buf_valid;
  logic [DATA_WIDTH:0]   buf_dout;
  logic [1:0]            buf_count;

  // ---------------- write side ----------------
  assign bus.s_axis_tready = !axis_areset;
  assign wr_beat           = bus.s_axis_tvalid && bus.s_axis_tready;

  always_comb begin
    w_state_nxt = w_state;
    w_addr      = (w_state == W_FIRST) ? bus.s_axis_wr_addr : w_addr_q + ADDR_WIDTH'(1);
    if (wr_beat) w_state_nxt = bus.s_axis_tlast ? W_FIRST : W_NEXT;
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      w_state  <= W_FIRST;
      w_addr_q <= '0;
    end else begin
      w_state <= w_state_nxt;
      if (wr_beat) w_addr_q <= w_addr;
    end
  end

  // Storage is never reset; non-blocking read next to write gives read-first behaviour.
  always_ff @(posedge axis_aclk) begin
    for (int l = 0; l < STRB_W; l++)
      if (wr_beat && bus.s_axis_tstrb[l]) mem[w_addr][l] <= bus.s_axis_tdata[l*8 +: 8];
    if (rd_issue) rd_data <= mem[rd_ptr];
  end

  // ---------------- read side ----------------
  // Only issue when the beat in flight plus buffered beats still leave a slot next cycle.
  always_comb begin
    r_state_nxt   = r_state;
    rd_ptr_nxt    = rd_ptr;
    rd_remain_nxt = rd_remain;
    rd_issue      = 1'b0;
    occ           = {1'b0, buf_count} + {2'b00, rd_vld} - {2'b00, rd_pop};
    room          = (occ < 3'd2);
    unique case (r_state)
      R_IDLE: if (bus.rd_start) begin
        rd_ptr_nxt    = bus.rd_addr;
        rd_remain_nxt = bus.rd_len;
        r_state_nxt   = R_RUN;
      end
      R_RUN: if (room) begin
        rd_issue   = 1'b1;
        rd_ptr_nxt = rd_ptr + ADDR_WIDTH'(1);
        if (rd_remain == '0) r_state_nxt   = R_DRAIN;
        else                 rd_remain_nxt = rd_remain - ADDR_WIDTH'(1);
      end
      R_DRAIN: if (rd_pop && bus.m_axis_tlast) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      r_state   <= R_IDLE;
      rd_ptr    <= '0;
      rd_remain <= '0;
      rd_vld    <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      r_state   <= r_state_nxt;
      rd_ptr    <= rd_ptr_nxt;
      rd_remain <= rd_remain_nxt;
      rd_vld    <= rd_issue;
      if (rd_issue) rd_last_q <= (rd_remain == '0);
    end
  end

  axis_skid_buf #(.WIDTH(DATA_WIDTH + 1)) u_skid (
    .clk   (axis_aclk),
    .rst   (axis_areset),
    .push  (rd_vld),
    .din   ({rd_last_q, rd_data}),
    .pop   (rd_pop),
    .valid (buf_valid),
    .dout  (buf_dout),
    .count (buf_count)
  );

  // Outputs are forced quiet during reset, before the registers have cleared.
  assign bus.m_axis_tvalid = buf_valid && !axis_areset;
  assign bus.m_axis_tdata  = bus.m_axis_tvalid ? buf_dout[DATA_WIDTH-1:0] : '0;
  assign bus.m_axis_tlast  = bus.m_axis_tvalid && buf_dout[DATA_WIDTH];
  assign bus.m_axis_tstrb  = {STRB_W{bus.m_axis_tvalid}};
  assign bus.rd_busy       = (r_state != R_IDLE) && !axis_areset;
  assign rd_pop            = bus.m_axis_tvalid && bus.m_axis_tready;
endmodule

// File: tb/tb_stream_burst_mem.sv
// Directed bench for stream_burst_mem: write bursts, strobes, wrap, stalls, read-first, reset abort.
module tb_stream_burst_mem;
  localparam int AW = 12;
  localparam int DW = 32;

  logic clk, rst;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] got_data [4096];
  bit          got_last [4096];
  int          n_beats, first_vld, first_acc, last_acc, stall_changes;
  bit          busy_start, busy_end, timed_out;

  stream_burst_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  stream_burst_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .axis_aclk   (clk),
    .axis_areset (rst),
    .bus         (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb, input bit last);
    bus.s_axis_wr_addr = addr;
    bus.s_axis_tdata   = data;
    bus.s_axis_tstrb   = strb;
    bus.s_axis_tlast   = last;
    bus.s_axis_tvalid  = 1'b1;
    step();
    bus.s_axis_tvalid  = 1'b0;
  endtask

  // Issues one read command and records accepted beats; optionally injects a write
  // beat in the first cycle after the command and re-pulses rd_start while busy.
  task automatic run_read(input logic [11:0] addr, input logic [11:0] len, input bit toggle,
                          input bit restart, input bit inj, input logic [11:0] inj_addr,
                          input logic [31:0] inj_data, input int max_cyc);
    int cyc;
    bit done, stalled;
    logic [32:0] held, cur;
    n_beats = 0; first_vld = -1; first_acc = -1; last_acc = -1;
    stall_changes = 0; timed_out = 0; stalled = 0; held = '0; done = 0; cyc = 0;
    bus.m_axis_tready = 1'b0;
    bus.rd_addr  = addr;
    bus.rd_len   = len;
    bus.rd_start = 1'b1;
    step();
    bus.rd_start = 1'b0;
    busy_start = bus.rd_busy;
    if (inj) begin
      bus.s_axis_wr_addr = inj_addr;
      bus.s_axis_tdata   = inj_data;
      bus.s_axis_tstrb   = 4'hF;
      bus.s_axis_tlast   = 1'b1;
      bus.s_axis_tvalid  = 1'b1;
    end
    while (!done) begin
      step();
      cyc++;
      bus.s_axis_tvalid = 1'b0;
      bus.rd_start = restart && (cyc == 1);
      if (restart) begin
        bus.rd_addr = 12'h000;
        bus.rd_len  = 12'h000;
      end
      bus.m_axis_tready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      cur = {bus.m_axis_tlast, bus.m_axis_tdata};
      if (stalled && (!bus.m_axis_tvalid || cur !== held)) stall_changes++;
      stalled = 0;
      if (bus.m_axis_tvalid) begin
        if (first_vld < 0) first_vld = cyc;
        if (bus.m_axis_tready) begin
          if (n_beats < 4096) begin
            got_data[n_beats] = bus.m_axis_tdata;
            got_last[n_beats] = bus.m_axis_tlast;
          end
          n_beats++;
          if (first_acc < 0) first_acc = cyc;
          last_acc = cyc;
          done = bus.m_axis_tlast;
        end else begin
          stalled = 1;
          held = cur;
        end
      end
      if (cyc >= max_cyc) begin
        timed_out = 1;
        done = 1;
      end
    end
    step();
    bus.rd_start = 1'b0;
    bus.m_axis_tready = 1'b0;
    busy_end = bus.rd_busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++; if (bus.s_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_tready got %b exp 0", bus.s_axis_tready); end
    checks++; if (bus.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b exp 0", bus.m_axis_tvalid); end
    checks++; if (bus.m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast got %b exp 0", bus.m_axis_tlast); end
    checks++; if (bus.m_axis_tdata !== 32'h0) begin errors++; $display("FAIL rst_tdata got %h exp 0", bus.m_axis_tdata); end
    checks++; if (bus.m_axis_tstrb !== 4'h0) begin errors++; $display("FAIL rst_tstrb got %h exp 0", bus.m_axis_tstrb); end
    checks++; if (bus.rd_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.rd_busy); end
    rst = 1'b0;
    step();
    checks++; if (bus.s_axis_tready !== 1'b1) begin errors++; $display("FAIL post_rst_tready got %b exp 1", bus.s_axis_tready); end
  endtask

  task automatic test_write_burst();
    logic [31:0] exp_d [3];
    exp_d[0] = 32'h22; exp_d[1] = 32'h33; exp_d[2] = 32'h44;
    // later beats carry a bogus base address that must be ignored
    wr(12'h001, 32'h22, 4'hF, 1'b0);
    wr(12'h555, 32'h33, 4'hF, 1'b0);
    wr(12'h555, 32'h44, 4'hF, 1'b1);
    run_read(12'h001, 12'd2, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 40);
    checks++; if (timed_out) begin errors++; $display("FAIL wburst_timeout got 1 exp 0"); end
    checks++; if (n_beats !== 3) begin errors++; $display("FAIL wburst_beats got %0d exp 3", n_beats); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (got_data[i] !== exp_d[i]) begin errors++; $display("FAIL wburst_data%0d got %h exp %h", i, got_data[i], exp_d[i]); end
      checks++; if (got_last[i] !== (i == 2)) begin errors++; $display("FAIL wburst_last%0d got %b exp %b", i, got_last[i], i == 2); end
    end
  endtask

  task automatic test_strobe();
    wr(12'h010, 32'hAABBCCDD, 4'hF, 1'b1);
    wr(12'h010, 32'h11223344, 4'h3, 1'b1);
    run_read(12'h010, 12'd0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 40);
    checks++; if (n_beats !== 1) begin errors++; $display("FAIL strb_beats got %0d exp 1", n_beats); end
    checks++; if (got_data[0] !== 32'hAABB3344) begin errors++; $display("FAIL strb_data got %h exp aabb3344", got_data[0]); end
    checks++; if (got_last[0] !== 1'b1) begin errors++; $display("FAIL strb_last got %b exp 1", got_last[0]); end
  endtask

  task automatic test_wrap_read();
    logic [31:0] exp_d [4];
    exp_d[0] = 32'hF0E; exp_d[1] = 32'hF0F; exp_d[2] = 32'hF00; exp_d[3] = 32'h22;
    wr(12'hFFE, 32'hF0E, 4'hF, 1'b0);
    wr(12'h000, 32'hF0F, 4'hF, 1'b0);
    wr(12'h000, 32'hF00, 4'hF, 1'b1);
    run_read(12'hFFE, 12'd3, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 40);
    checks++; if (busy_start !== 1'b1) begin errors++; $display("FAIL wrap_busy_start got %b exp 1", busy_start); end
    checks++; if (first_vld !== 2) begin errors++; $display("FAIL wrap_latency got %0d exp 2", first_vld); end
    checks++; if (n_beats !== 4) begin errors++; $display("FAIL wrap_beats got %0d exp 4", n_beats); end
    checks++; if (last_acc - first_acc !== 3) begin errors++; $display("FAIL wrap_b2b got %0d exp 3", last_acc - first_acc); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (got_data[i] !== exp_d[i]) begin errors++; $display("FAIL wrap_data%0d got %h exp %h", i, got_data[i], exp_d[i]); end
      checks++; if (got_last[i] !== (i == 3)) begin errors++; $display("FAIL wrap_last%0d got %b exp %b", i, got_last[i], i == 3); end
    end
    checks++; if (busy_end !== 1'b0) begin errors++; $display("FAIL wrap_busy_end got %b exp 0", busy_end); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 8; i++) wr(12'h100, 32'h1000 + i, 4'hF, i == 7);
    run_read(12'h100, 12'd7, 1'b1, 1'b1, 1'b0, 12'h0, 32'h0, 80);
    checks++; if (timed_out) begin errors++; $display("FAIL stall_timeout got 1 exp 0"); end
    checks++; if (n_beats !== 8) begin errors++; $display("FAIL stall_beats got %0d exp 8", n_beats); end
    checks++; if (stall_changes !== 0) begin errors++; $display("FAIL stall_stable got %0d exp 0", stall_changes); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (got_data[i] !== 32'h1000 + i) begin errors++; $display("FAIL stall_data%0d got %h exp %h", i, got_data[i], 32'h1000 + i); end
    end
    checks++; if (got_last[7] !== 1'b1 || got_last[6] !== 1'b0) begin errors++; $display("FAIL stall_last got %b%b exp 01", got_last[6], got_last[7]); end
  endtask

  task automatic test_read_first();
    wr(12'h200, 32'h5555AAAA, 4'hF, 1'b1);
    run_read(12'h200, 12'd0, 1'b0, 1'b0, 1'b1, 12'h200, 32'h12345678, 40);
    checks++; if (got_data[0] !== 32'h5555AAAA) begin errors++; $display("FAIL rdfirst_old got %h exp 5555aaaa", got_data[0]); end
    run_read(12'h200, 12'd0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 40);
    checks++; if (got_data[0] !== 32'h12345678) begin errors++; $display("FAIL rdfirst_new got %h exp 12345678", got_data[0]); end
  endtask

  task automatic test_full_wrap();
    run_read(12'h005, 12'hFFF, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 5000);
    checks++; if (n_beats !== 4096) begin errors++; $display("FAIL full_beats got %0d exp 4096", n_beats); end
    checks++; if (last_acc - first_acc !== 4095) begin errors++; $display("FAIL full_b2b got %0d exp 4095", last_acc - first_acc); end
    checks++; if (got_data[12'h00B] !== 32'hAABB3344) begin errors++; $display("FAIL full_0x010 got %h exp aabb3344", got_data[12'h00B]); end
    checks++; if (got_data[12'hFF9] !== 32'hF0E) begin errors++; $display("FAIL full_0xffe got %h exp f0e", got_data[12'hFF9]); end
    checks++; if (got_data[12'hFFC] !== 32'h22) begin errors++; $display("FAIL full_0x001 got %h exp 22", got_data[12'hFFC]); end
    checks++; if (got_last[4095] !== 1'b1 || got_last[4094] !== 1'b0) begin errors++; $display("FAIL full_last got %b%b exp 01", got_last[4094], got_last[4095]); end
  endtask

  task automatic test_reset_mid();
    int acc, extra, cyc;
    acc = 0; extra = 0; cyc = 0;
    bus.m_axis_tready = 1'b1;
    bus.rd_addr  = 12'h100;
    bus.rd_len   = 12'd7;
    bus.rd_start = 1'b1;
    step();
    bus.rd_start = 1'b0;
    while (acc < 2 && cyc < 20) begin
      step();
      cyc++;
      if (bus.m_axis_tvalid) acc++;
    end
    checks++; if (acc !== 2) begin errors++; $display("FAIL rstmid_pre_beats got %0d exp 2", acc); end
    step();
    rst = 1'b1;
    step();
    checks++; if (bus.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid got %b exp 0", bus.m_axis_tvalid); end
    checks++; if (bus.rd_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", bus.rd_busy); end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.m_axis_tvalid) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL rstmid_extra got %0d exp 0", extra); end
    checks++; if (bus.s_axis_tready !== 1'b1) begin errors++; $display("FAIL rstmid_tready got %b exp 1", bus.s_axis_tready); end
    run_read(12'h010, 12'd0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 40);
    checks++; if (got_data[0] !== 32'hAABB3344) begin errors++; $display("FAIL rstmid_keep0 got %h exp aabb3344", got_data[0]); end
    run_read(12'h102, 12'd0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 40);
    checks++; if (got_data[0] !== 32'h1002) begin errors++; $display("FAIL rstmid_keep1 got %h exp 1002", got_data[0]); end
  endtask

  initial begin
    rst = 1'b1;
    bus.s_axis_wr_addr = '0; bus.s_axis_tdata = '0; bus.s_axis_tstrb = '0;
    bus.s_axis_tvalid  = 1'b0; bus.s_axis_tlast = 1'b0;
    bus.rd_start = 1'b0; bus.rd_addr = '0; bus.rd_len = '0; bus.m_axis_tready = 1'b0;
    test_reset();
    test_write_burst();
    test_strobe();
    test_wrap_read();
    test_stall();
    test_read_first();
    test_full_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
